// File: rtl/picosoc_iomem_bridge.sv
// picosoc_iomem_bridge
// Routes CPU native-bus accesses into NUM_SLAVES equal address windows with
// registered slave strobes. Accesses outside the windows, or slaves that stay
// silent for TIMEOUT cycles, complete with ERR_RDATA. The first such fault is
// kept in a sticky error register that drives err_irq.
module picosoc_iomem_bridge #(
    parameter int          NUM_SLAVES  = 4,
    parameter logic [31:0] ADDR_BASE   = 32'h0300_0000,
    parameter int          SLAVE_SHIFT = 20,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [3:0]               m_wstrb,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     err_irq,
    output logic [31:0]              err_addr,
    output logic [1:0]               err_cause,
    input  logic                     err_clr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    // Keeps only the byte offset inside one slave window.
    localparam logic [31:0] OFF_MASK = (SLAVE_SHIFT >= 32) ? 32'hFFFF_FFFF
                                                           : ((32'd1 << SLAVE_SHIFT) - 32'd1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_DECODE  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             addr_q, addr_d;
    logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
    logic [3:0]              s_wstrb_q, s_wstrb_d;
    logic [31:0]             s_addr_q, s_addr_d;
    logic [31:0]             s_wdata_q, s_wdata_d;
    logic                    m_ready_q, m_ready_d;
    logic [31:0]             m_rdata_q, m_rdata_d;
    logic                    err_irq_q, err_irq_d;
    logic [31:0]             err_addr_q, err_addr_d;
    logic [1:0]              err_cause_q, err_cause_d;

    logic [31:0]             win_off;
    logic [31:0]             win_idx;
    logic                    in_window;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic                    fault;
    logic [1:0]              fault_cause;
    logic [31:0]             fault_addr;

    // Window decode of the incoming CPU address.
    always_comb begin
        win_off   = m_addr - ADDR_BASE;
        win_idx   = win_off >> SLAVE_SHIFT;
        in_window = (m_addr >= ADDR_BASE) && (win_idx < 32'(NUM_SLAVES));
    end

    // Response of the slave currently being accessed; others are ignored.
    always_comb begin
        sel_ready = s_ready[idx_q];
        sel_rdata = s_rdata[{idx_q, 5'b00000} +: 32];
    end

    // Next-state logic for the access FSM, slave strobes and error register.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        s_valid_d   = s_valid_q;
        s_wstrb_d   = s_wstrb_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        m_ready_d   = m_ready_q;
        m_rdata_d   = m_rdata_q;
        err_irq_d   = err_irq_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
        fault       = 1'b0;
        fault_cause = CAUSE_NONE;
        fault_addr  = addr_q;

        case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                m_ready_d = 1'b0;
                m_rdata_d = '0;
                if (m_valid) begin
                    addr_d    = m_addr;
                    s_wstrb_d = m_wstrb;
                    s_wdata_d = m_wdata;
                    s_addr_d  = win_off & OFF_MASK;
                    if (in_window) begin
                        idx_d     = win_idx[IDX_W-1:0];
                        s_valid_d = NUM_SLAVES'(1) << win_idx[IDX_W-1:0];
                        state_d   = ST_ACCESS;
                    end else begin
                        // No slave is touched; RESP raises m_ready one cycle later.
                        s_valid_d   = '0;
                        m_rdata_d   = ERR_RDATA;
                        fault       = 1'b1;
                        fault_cause = CAUSE_DECODE;
                        fault_addr  = m_addr;
                        state_d     = ST_RESP;
                    end
                end
            end

            ST_ACCESS: begin
                if (sel_ready) begin
                    // Slave completion has priority over a coincident timeout.
                    s_valid_d = '0;
                    m_rdata_d = sel_rdata;
                    m_ready_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    s_valid_d   = '0;
                    m_rdata_d   = ERR_RDATA;
                    m_ready_d   = 1'b1;
                    timer_d     = '0;
                    fault       = 1'b1;
                    fault_cause = CAUSE_TIMEOUT;
                    fault_addr  = addr_q;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_RESP: begin
                timer_d = '0;
                if (m_ready_q) begin
                    // Completion pulse has been shown for one cycle.
                    m_ready_d = 1'b0;
                    m_rdata_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    m_ready_d = 1'b1;
                end
            end

            default: begin
                s_valid_d = '0;
                m_ready_d = 1'b0;
                m_rdata_d = '0;
                timer_d   = '0;
                state_d   = ST_IDLE;
            end
        endcase

        // Sticky error capture: first fault kept, a fault beats a coincident clear.
        if (fault && (!err_irq_q || err_clr)) begin
            err_irq_d   = 1'b1;
            err_addr_d  = fault_addr;
            err_cause_d = fault_cause;
        end else if (err_clr) begin
            err_irq_d   = 1'b0;
            err_addr_d  = '0;
            err_cause_d = CAUSE_NONE;
        end
    end

    // State and output registers; reset drops every output immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            s_valid_q   <= '0;
            s_wstrb_q   <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            m_ready_q   <= 1'b0;
            m_rdata_q   <= '0;
            err_irq_q   <= 1'b0;
            err_addr_q  <= '0;
            err_cause_q <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            s_valid_q   <= s_valid_d;
            s_wstrb_q   <= s_wstrb_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            m_ready_q   <= m_ready_d;
            m_rdata_q   <= m_rdata_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign m_ready   = m_ready_q;
    assign m_rdata   = m_rdata_q;
    assign s_valid   = s_valid_q;
    assign s_wstrb   = s_wstrb_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;
    assign err_cause = err_cause_q;

endmodule

// File: tb/tb_picosoc_iomem_bridge.sv
// Testbench for picosoc_iomem_bridge: directed scenarios followed by random
// accesses, all checked against a transaction-level model of the bridge.
module tb_picosoc_iomem_bridge;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic          clk;
    logic          resetn;
    logic          m_valid;
    logic          m_ready;
    logic [3:0]    m_wstrb;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;
    logic [NS-1:0] s_valid;
    logic [NS-1:0] s_ready;
    logic [3:0]    s_wstrb;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [32*NS-1:0] s_rdata;
    logic          err_irq;
    logic [31:0]   err_addr;
    logic [1:0]    err_cause;
    logic          err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference error register
    logic        irq_m;
    logic [31:0] eaddr_m;
    logic [1:0]  ecause_m;

    picosoc_iomem_bridge #(
        .NUM_SLAVES (NS),
        .ADDR_BASE  (BASE),
        .SLAVE_SHIFT(20),
        .TIMEOUT    (TO),
        .ERR_RDATA  (ERRD)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_wstrb  (m_wstrb),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_wstrb  (s_wstrb),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .err_irq  (err_irq),
        .err_addr (err_addr),
        .err_cause(err_cause),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "_irq"},   32'(err_irq),   32'(irq_m));
        chk({tag, "_addr"},  err_addr,       eaddr_m);
        chk({tag, "_cause"}, 32'(err_cause), 32'(ecause_m));
    endtask

    // One CPU access. Called #1 after a rising edge with the bridge idle.
    // w = wait cycles before the selected slave answers (w >= TO: never in time).
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int w,
                              input logic [31:0] sdata, input logic clr);
        logic [31:0] idx;
        logic [31:0] exp_saddr;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_sv;
        bit          fault;
        bit          done;
        int          lat;

        idx       = (addr - BASE) >> 20;
        fault     = (addr < BASE) || (idx >= 32'(NS));
        exp_saddr = (addr - BASE) & 32'h000F_FFFF;
        if (fault) begin
            lat = 2;
            exp_rdata = ERRD;
        end else if (w < TO) begin
            lat = w + 2;
            exp_rdata = sdata;
        end else begin
            lat = TO + 1;
            exp_rdata = ERRD;
        end

        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        err_clr = clr;

        // Error register at the request-sampling edge
        if (fault && (!irq_m || clr)) begin
            irq_m = 1'b1; eaddr_m = addr; ecause_m = 2'b01;
        end else if (clr) begin
            irq_m = 1'b0; eaddr_m = '0; ecause_m = 2'b00;
        end

        done = 0;
        for (int c = 1; c <= TO + 8 && !done; c++) begin
            @(posedge clk); #1;
            err_clr = 1'b0;
            exp_sv = (!fault && c < lat) ? (4'b0001 << idx[1:0]) : 4'b0000;
            chk("s_valid", 32'(s_valid), 32'(exp_sv));
            if (!fault && c < lat) begin
                chk("s_addr",  s_addr,          exp_saddr);
                chk("s_wdata", s_wdata,         wdata);
                chk("s_wstrb", 32'(s_wstrb),    32'(wstrb));
            end
            if (m_ready) begin
                chk("latency", 32'(c), 32'(lat));
                chk("m_rdata", m_rdata, exp_rdata);
                done = 1;
            end else begin
                if (!fault) chk("m_rdata_wait", m_rdata, 32'h0);
                for (int j = 0; j < NS; j++) begin
                    s_rdata[32*j +: 32] = $urandom;
                    s_ready[j] = (fault || 32'(j) != idx) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                if (!fault && c == w + 1) begin
                    s_ready[idx[1:0]] = 1'b1;
                    s_rdata[32*idx[1:0] +: 32] = sdata;
                end
            end
        end
        if (!done) chk("m_ready_bound", 32'h0, 32'h1);

        if (!fault && w >= TO && !irq_m) begin
            irq_m = 1'b1; eaddr_m = addr; ecause_m = 2'b10;
        end

        m_valid = 1'b0;
        s_ready = '0;
        @(posedge clk); #1;
        chk("m_ready_pulse", 32'(m_ready), 32'h0);
        chk("m_rdata_idle",  m_rdata,      32'h0);
        chk_err("err");
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        irq_m = 1'b0; eaddr_m = '0; ecause_m = 2'b00;
        chk_err("clr");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_valid"},  32'(s_valid),   32'h0);
        chk({tag, "_m_ready"},  32'(m_ready),   32'h0);
        chk({tag, "_m_rdata"},  m_rdata,        32'h0);
        chk({tag, "_s_addr"},   s_addr,         32'h0);
        chk({tag, "_s_wdata"},  s_wdata,        32'h0);
        chk({tag, "_s_wstrb"},  32'(s_wstrb),   32'h0);
        chk({tag, "_err_irq"},  32'(err_irq),   32'h0);
        chk({tag, "_err_addr"}, err_addr,       32'h0);
        chk({tag, "_err_cause"},32'(err_cause), 32'h0);
    endtask

    initial begin
        logic [31:0] ridx;
        logic [31:0] raddr;
        logic [3:0]  rstrb;
        int          r;

        resetn  = 1'b0;
        m_valid = 1'b0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_ready = '0;
        s_rdata = '0;
        err_clr = 1'b0;
        irq_m = 1'b0; eaddr_m = '0; ecause_m = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single-cycle slave read
        run_access(32'h0310_0004, 32'h0, 4'b0000, 0, 32'h1234_5678, 1'b0);
        // Write with 5 wait states to slave 3
        run_access(32'h0330_0010, 32'hA5A5_A5A5, 4'b0011, 5, 32'h0BAD_F00D, 1'b0);
        // Decode fault just past the last window
        run_access(32'h0340_0000, 32'h0, 4'b0000, 0, 32'h0, 1'b0);
        do_clr();
        // Timeout on slave 0, then a second fault that must not overwrite
        run_access(32'h0300_0020, 32'h0, 4'b0000, 100, 32'h0, 1'b0);
        run_access(32'h0350_0000, 32'h0, 4'b0000, 0, 32'h0, 1'b0);
        // Clear coincident with a new decode fault, then clear alone
        run_access(32'h02FF_FFFC, 32'h0, 4'b1111, 0, 32'h0, 1'b1);
        do_clr();
        // Slave answering exactly on the timeout cycle
        run_access(32'h0320_0100, 32'h0, 4'b0000, TO - 1, 32'hCAFE_0001, 1'b0);

        // Reset in the middle of an access
        m_valid = 1'b1;
        m_addr  = 32'h0300_0010;
        m_wstrb = 4'b0000;
        s_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_s_valid_before", 32'(s_valid), 32'h1);
        resetn = 1'b0;
        #1;
        m_valid = 1'b0;
        irq_m = 1'b0; eaddr_m = '0; ecause_m = 2'b00;
        chk_all_zero("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        run_access(32'h0310_0008, 32'h0, 4'b0000, 2, 32'h5555_AAAA, 1'b0);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                ridx  = 32'($urandom_range(0, NS - 1));
                raddr = BASE + (ridx << 20) + ($urandom & 32'h000F_FFFC);
            end else if (r < 9) begin
                ridx  = 32'($urandom_range(NS, 15));
                raddr = BASE + (ridx << 20) + ($urandom & 32'h000F_FFFC);
            end else begin
                raddr = 32'h0200_0000 | ($urandom & 32'h00FF_FFFC);
            end
            rstrb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            run_access(raddr, $urandom, rstrb, $urandom_range(0, 10), $urandom,
                       ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 7) == 0) do_clr();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
